// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS core, with a memory-latency dwell counter.
// Define MULTICYCLE_CTRL_JUMP_EN to decode opcode 000010 (j) into the JUMP state.
module multicycle_control #(
  parameter int MEM_LAT = 1,
  parameter int ST_W    = 4
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic [5:0]      Op,
  output logic            IorD,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            Branch,
  output logic [1:0]      PCSrc,
  output logic            AluSrcA,
  output logic [1:0]      AluSrcB,
  output logic [1:0]      AluOp,
  output logic            RegWrite,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            Illegal,
  output logic [ST_W-1:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MULTICYCLE_CTRL_JUMP_EN
  localparam logic [5:0] OP_J    = 6'b000010;
`endif
  localparam logic [2:0] LAST    = 3'(MEM_LAT - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
  logic       mem_st, last_beat;
  logic       mem_wr, ir_wr, pc_wr, br, reg_wr;

  assign mem_st    = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign last_beat = (cnt_q == LAST);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= 3'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    cnt_d     = (mem_st && !last_beat) ? cnt_q + 3'd1 : 3'd0;
    case (state_q)
      S_FETCH:  if (last_beat) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MULTICYCLE_CTRL_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      // Only lw/sw reach here; anything other than sw is treated as a load.
      S_MEMADR: state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (last_beat) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (last_beat) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    IorD     = 1'b0;
    mem_wr   = 1'b0;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    br       = 1'b0;
    PCSrc    = 2'b00;
    AluSrcA  = 1'b0;
    AluSrcB  = 2'b00;
    AluOp    = 2'b00;
    reg_wr   = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    case (state_q)
      S_FETCH: begin
        AluSrcB = 2'b01;
        ir_wr   = last_beat;
        pc_wr   = last_beat;
      end
      S_DECODE: AluSrcB = 2'b11;
      S_MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        reg_wr   = 1'b1;
      end
      S_MEMWR: begin
        IorD   = 1'b1;
        mem_wr = last_beat;
      end
      S_EXEC: begin
        AluSrcA = 1'b1;
        AluOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst = 1'b1;
        reg_wr = 1'b1;
      end
      S_BRANCH: begin
        AluSrcA = 1'b1;
        AluOp   = 2'b01;
        PCSrc   = 2'b01;
        br      = 1'b1;
      end
      S_ADDIEX: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
      end
      S_ADDIWB: reg_wr = 1'b1;
      S_JUMP: begin
        PCSrc = 2'b10;
        pc_wr = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset leaves the FSM in FETCH, whose final beat (MEM_LAT=1) would otherwise
  // assert the PC/IR loads; all write strobes are masked while reset is held.
  assign MemWrite = mem_wr & Rst_n;
  assign IRWrite  = ir_wr  & Rst_n;
  assign PCWrite  = pc_wr  & Rst_n;
  assign Branch   = br     & Rst_n;
  assign RegWrite = reg_wr & Rst_n;
  assign Illegal  = illegal_q;
  assign State    = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: one instance at MEM_LAT=1 and one at MEM_LAT=3,
// each driven with directed and random instruction streams against a cycle-queue model.
module tb_multicycle_control;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic       iord, memwrite, irwrite, pcwrite, branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb, aluop;
    logic       regwrite, regdst, memtoreg, illegal;
    logic [3:0] state;
  } ov_t;

  typedef struct packed {
    ov_t        v;
    logic [5:0] op;
  } ent_t;

  logic                 Clk;
  logic [1:0]           rst_n;
  logic [1:0][5:0]      op;
  logic [1:0]           iord, memwrite, irwrite, pcwrite, branch;
  logic [1:0][1:0]      pcsrc, alusrcb, aluop;
  logic [1:0]           alusrca, regwrite, regdst, memtoreg, illegal;
  logic [1:0][3:0]      state;

  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];
  bit   pend_ill;

  multicycle_control #(.MEM_LAT(1), .ST_W(4)) u_lat1 (
    .Clk(Clk), .Rst_n(rst_n[0]), .Op(op[0]),
    .IorD(iord[0]), .MemWrite(memwrite[0]), .IRWrite(irwrite[0]), .PCWrite(pcwrite[0]),
    .Branch(branch[0]), .PCSrc(pcsrc[0]), .AluSrcA(alusrca[0]), .AluSrcB(alusrcb[0]),
    .AluOp(aluop[0]), .RegWrite(regwrite[0]), .RegDst(regdst[0]), .MemtoReg(memtoreg[0]),
    .Illegal(illegal[0]), .State(state[0])
  );

  multicycle_control #(.MEM_LAT(3), .ST_W(4)) u_lat3 (
    .Clk(Clk), .Rst_n(rst_n[1]), .Op(op[1]),
    .IorD(iord[1]), .MemWrite(memwrite[1]), .IRWrite(irwrite[1]), .PCWrite(pcwrite[1]),
    .Branch(branch[1]), .PCSrc(pcsrc[1]), .AluSrcA(alusrca[1]), .AluSrcB(alusrcb[1]),
    .AluOp(aluop[1]), .RegWrite(regwrite[1]), .RegDst(regdst[1]), .MemtoReg(memtoreg[1]),
    .Illegal(illegal[1]), .State(state[1])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic ov_t obs(int d);
    ov_t o;
    o.iord = iord[d];         o.memwrite = memwrite[d]; o.irwrite = irwrite[d];
    o.pcwrite = pcwrite[d];   o.branch = branch[d];     o.pcsrc = pcsrc[d];
    o.alusrca = alusrca[d];   o.alusrcb = alusrcb[d];   o.aluop = aluop[d];
    o.regwrite = regwrite[d]; o.regdst = regdst[d];     o.memtoreg = memtoreg[d];
    o.illegal = illegal[d];   o.state = state[d];
    return o;
  endfunction

  // Expected outputs for one cycle in a given step; fin marks the last memory beat.
  function automatic ov_t exp_vec(int st, bit fin, bit ill);
    ov_t v = '0;
    v.state   = st[3:0];
    v.illegal = ill;
    case (st)
      0:  begin v.alusrcb = 2'b01; v.irwrite = fin; v.pcwrite = fin; end
      1:  v.alusrcb = 2'b11;
      2:  begin v.alusrca = 1'b1; v.alusrcb = 2'b10; end
      3:  v.iord = 1'b1;
      4:  begin v.memtoreg = 1'b1; v.regwrite = 1'b1; end
      5:  begin v.iord = 1'b1; v.memwrite = fin; end
      6:  begin v.alusrca = 1'b1; v.aluop = 2'b10; end
      7:  begin v.regdst = 1'b1; v.regwrite = 1'b1; end
      8:  begin v.alusrca = 1'b1; v.aluop = 2'b01; v.pcsrc = 2'b01; v.branch = 1'b1; end
      9:  begin v.alusrca = 1'b1; v.alusrcb = 2'b10; end
      10: v.regwrite = 1'b1;
      11: begin v.pcsrc = 2'b10; v.pcwrite = 1'b1; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic push(int st, bit fin, logic [5:0] o);
    ent_t e;
    e.v  = exp_vec(st, fin, (st == 0) && pend_ill);
    e.op = o;
    if (st == 0) pend_ill = 1'b0;
    exp_q.push_back(e);
  endtask

  // Expand one instruction into its expected cycle-by-cycle sequence.
  task automatic gen(int lat, logic [5:0] o);
    for (int i = 0; i < lat; i++) push(0, i == lat - 1, o);
    push(1, 1'b0, o);
    case (o)
      OP_LW: begin
        push(2, 1'b0, o);
        for (int i = 0; i < lat; i++) push(3, i == lat - 1, o);
        push(4, 1'b0, o);
      end
      OP_SW: begin
        push(2, 1'b0, o);
        for (int i = 0; i < lat; i++) push(5, i == lat - 1, o);
      end
      OP_R:    begin push(6, 1'b0, o); push(7, 1'b0, o); end
      OP_BEQ:  push(8, 1'b0, o);
      OP_ADDI: begin push(9, 1'b0, o); push(10, 1'b0, o); end
`ifdef MULTICYCLE_CTRL_JUMP_EN
      OP_J:    push(11, 1'b0, o);
`endif
      default: pend_ill = 1'b1;
    endcase
  endtask

  task automatic test_reset(int d);
    ov_t o;
    ov_t ex;
    rst_n[d] = 1'b0;
    ex = exp_vec(0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk); #1;
      o = obs(d);
      checks++;
      if (o !== ex) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got %h expected %h", d, o, ex);
      end
    end
  endtask

  task automatic test_instr_stream(int d);
    int         lat = lat_of(d);
    int         cyc = 0;
    ent_t       e;
    ov_t        o;
    logic [5:0] r;
    rst_n[d] = 1'b0;
    pend_ill = 1'b0;
    exp_q.delete();
    gen(lat, OP_LW);  gen(lat, OP_R);    gen(lat, OP_BEQ);  gen(lat, OP_SW);
    gen(lat, OP_BAD); gen(lat, OP_J);    gen(lat, OP_ADDI); gen(lat, OP_BAD);
    gen(lat, OP_BAD); gen(lat, OP_R);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0: r = OP_LW;   1: r = OP_SW;  2: r = OP_R;   3: r = OP_BEQ;
        4: r = OP_ADDI; 5: r = OP_J;   6: r = OP_BAD;
        default: r = 6'($urandom);
      endcase
      gen(lat, r);
    end
    gen(lat, OP_R);
    @(negedge Clk);
    rst_n[d] = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      #1;
      o = obs(d);
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL stream dut%0d cycle %0d got %h expected %h", d, cyc, o, e.v);
      end
      op[d] = (e.v.state == 4'd1 || e.v.state == 4'd2) ? e.op : 6'($urandom);
      cyc++;
      @(negedge Clk);
    end
  endtask

  task automatic test_async_reset(int d);
    int  lat = lat_of(d);
    ov_t o;
    ov_t ex;
    rst_n[d] = 1'b0;
    op[d]    = OP_R;
    @(negedge Clk);
    rst_n[d] = 1'b1;
    repeat (lat + 1) @(negedge Clk);
    #1;
    checks++;
    if (state[d] !== 4'd6) begin
      errors++;
      $display("FAIL reach_exec dut%0d state %0d expected 6", d, state[d]);
    end
    #1 rst_n[d] = 1'b0;
    #1;
    o  = obs(d);
    ex = exp_vec(0, 1'b0, 1'b0);
    checks++;
    if (o !== ex) begin
      errors++;
      $display("FAIL async_reset dut%0d got %h expected %h", d, o, ex);
    end
    @(negedge Clk);
    rst_n[d] = 1'b1;
    op[d]    = 6'($urandom);
    for (int i = 0; i < lat; i++) begin
      #1;
      o  = obs(d);
      ex = exp_vec(0, i == lat - 1, 1'b0);
      checks++;
      if (o !== ex) begin
        errors++;
        $display("FAIL resume_fetch dut%0d beat %0d got %h expected %h", d, i, o, ex);
      end
      @(negedge Clk);
    end
    #1;
    checks++;
    if (state[d] !== 4'd1) begin
      errors++;
      $display("FAIL resume_decode dut%0d state %0d expected 1", d, state[d]);
    end
  endtask

  initial begin
    rst_n = 2'b00;
    op    = '0;
    test_reset(0);
    test_reset(1);
    test_instr_stream(0);
    test_instr_stream(1);
    test_async_reset(0);
    test_async_reset(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
